// File: rtl/hilo_pkg.sv
`default_nettype none
// ============================================================================
// Module  : hilo_pkg
// Brief   : Shared encodings, state type and default watchdog limit for hilo_unit.
// Revision: 1.0 - initial release
// ============================================================================
package hilo_pkg;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_MULT = 2'b01,
        OP_MTHI = 2'b10,
        OP_MTLO = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10
    } state_e;

    localparam int unsigned DEFAULT_TIMEOUT = 64;

endpackage
`default_nettype wire

// File: rtl/hilo_if.sv
`default_nettype none
// ============================================================================
// Module  : hilo_if
// Brief   : Control-unit and divider/multiplier signals seen by hilo_unit.
// Revision: 1.0 - initial release
// ============================================================================
interface hilo_if;
    logic        op_valid;
    logic [1:0]  op_type;
    logic [31:0] op_data;
    logic        op_ready;
    logic        rd_req;
    logic        stall;
    logic        div_start;
    logic        div_done;
    logic        div_zero;
    logic [31:0] div_hi;
    logic [31:0] div_lo;
    logic        mult_start;
    logic        mult_done;
    logic [31:0] mult_hi;
    logic [31:0] mult_lo;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        div_zero_exc;
    logic        timeout_err;

    modport slave (
        input  op_valid, op_type, op_data, rd_req,
        input  div_done, div_zero, div_hi, div_lo,
        input  mult_done, mult_hi, mult_lo,
        output op_ready, stall, div_start, mult_start,
        output hi, lo, busy, div_zero_exc, timeout_err
    );

    modport master (
        output op_valid, op_type, op_data, rd_req,
        output div_done, div_zero, div_hi, div_lo,
        output mult_done, mult_hi, mult_lo,
        input  op_ready, stall, div_start, mult_start,
        input  hi, lo, busy, div_zero_exc, timeout_err
    );
endinterface
`default_nettype wire

// File: rtl/hilo_watchdog.sv
`default_nettype none
// ============================================================================
// Module  : hilo_watchdog
// Brief   : Load/decrement counter bounding how long hilo_unit waits on a unit.
// Revision: 1.0 - initial release
// ============================================================================
module hilo_watchdog #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  logic dec_i,
    output logic expired_o
);
    localparam int unsigned      CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = LOAD_VAL;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Flags the decrement that takes the count to zero, so the caller can exit on this edge.
    assign expired_o = dec_i && (count_q <= CNT_W'(1));

endmodule
`default_nettype wire

// File: rtl/hilo_unit.sv
`default_nettype none
// ============================================================================
// Module  : hilo_unit
// Brief   : Sequences DIV/MULT/MTHI/MTLO, holds architectural HI/LO, stalls reads.
// Revision: 1.0 - initial release
// ============================================================================
module hilo_unit
    import hilo_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic  clk,
    input  logic  reset,
    hilo_if.slave bus
);
    state_e      state_q, state_d;
    op_e         op_q, op_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        div_zero_exc_q, div_zero_exc_d;
    logic        timeout_err_q, timeout_err_d;

    logic        wd_load, wd_dec, wd_expired;
    logic        sel_is_div, sel_done;
    logic [31:0] sel_hi, sel_lo;

    hilo_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk       (clk),
        .reset     (reset),
        .load_i    (wd_load),
        .dec_i     (wd_dec),
        .expired_o (wd_expired)
    );

    // Only the unit that was started is looked at; the other unit's done is ignored.
    assign sel_is_div = (op_q == OP_DIV);
    assign sel_done   = sel_is_div ? bus.div_done : bus.mult_done;
    assign sel_hi     = sel_is_div ? bus.div_hi   : bus.mult_hi;
    assign sel_lo     = sel_is_div ? bus.div_lo   : bus.mult_lo;

    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        hi_d           = hi_q;
        lo_d           = lo_q;
        div_zero_exc_d = 1'b0;
        timeout_err_d  = 1'b0;
        wd_load        = 1'b0;
        wd_dec         = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.op_valid) begin
                    case (op_e'(bus.op_type))
                        OP_MTHI: hi_d = bus.op_data;
                        OP_MTLO: lo_d = bus.op_data;
                        default: begin
                            op_d    = op_e'(bus.op_type);
                            state_d = ISSUE;
                        end
                    endcase
                end
            end
            ISSUE: begin
                wd_load = 1'b1;
                state_d = WAIT;
            end
            WAIT: begin
                wd_dec = 1'b1;
                if (sel_is_div && bus.div_zero) begin
                    div_zero_exc_d = 1'b1;
                    state_d        = IDLE;
                end else if (sel_done) begin
                    hi_d    = sel_hi;
                    lo_d    = sel_lo;
                    state_d = IDLE;
                end else if (wd_expired) begin
                    timeout_err_d = 1'b1;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            op_q           <= OP_DIV;
            hi_q           <= '0;
            lo_q           <= '0;
            div_zero_exc_q <= 1'b0;
            timeout_err_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            hi_q           <= hi_d;
            lo_q           <= lo_d;
            div_zero_exc_q <= div_zero_exc_d;
            timeout_err_q  <= timeout_err_d;
        end
    end

    assign bus.op_ready     = (state_q == IDLE);
    assign bus.busy         = (state_q != IDLE);
    assign bus.stall        = bus.rd_req && (state_q != IDLE);
    assign bus.div_start    = (state_q == ISSUE) && sel_is_div;
    assign bus.mult_start   = (state_q == ISSUE) && !sel_is_div;
    assign bus.hi           = hi_q;
    assign bus.lo           = lo_q;
    assign bus.div_zero_exc = div_zero_exc_q;
    assign bus.timeout_err  = timeout_err_q;

endmodule
`default_nettype wire

// File: doc/hilo_unit.md
# hilo_unit

Sequencing and result-holding stage between the control unit and the multicycle divider/multiplier. It accepts DIV/MULT/MTHI/MTLO operations, issues a one-cycle start pulse to the selected arithmetic unit, and waits for its completion. It then commits the unit's hi/lo outputs into the architectural HI/LO registers. It stalls MFHI/MFLO reads while an operation is in flight, and reports divide-by-zero and watchdog timeouts.

## Interface
- TIMEOUT, 64: maximum cycles spent in WAIT before abort; must be ≥ 40.
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- op_valid  in  1  operation request
- op_type  in  2  00 DIV, 01 MULT, 10 MTHI, 11 MTLO
- op_data  in  32  write data for MTHI/MTLO
- op_ready  out  1  high only in IDLE
- rd_req  in  1  MFHI/MFLO in decode
- stall  out  1  rd_req && state != IDLE
- div_start  out  1  one-cycle start pulse to divider
- div_done  in  1  divider finished (level; may stay high after completion)
- div_zero  in  1  divider reports divisor == 0
- div_hi, div_lo  in  32 each  divider remainder/quotient
- mult_start  out  1  one-cycle start pulse to multiplier
- mult_done  in  1  multiplier finished (level)
- mult_hi, mult_lo  in  32 each  product upper/lower word
- hi, lo  out  32 each  architectural HI/LO
- busy  out  1  state != IDLE
- div_zero_exc  out  1  one-cycle pulse
- timeout_err  out  1  one-cycle pulse

## Operation
- Reset values: hi = lo = 0; all pulse outputs 0; busy = 0; op_ready = 1; state IDLE.
- States:
  - IDLE: on op_valid, MTHI writes op_data to hi and MTLO writes op_data to lo at that edge; the state stays IDLE. On op_valid with DIV/MULT, op_type is latched and the state moves to ISSUE.
  - ISSUE: asserts div_start or mult_start for exactly one cycle, loads the watchdog with TIMEOUT, then moves to WAIT.
  - WAIT: samples the selected unit only; the other unit's done is ignored. The watchdog decrements every cycle. Exits are checked in this priority order:
    1. div_zero (DIV only): pulse div_zero_exc, leave HI/LO unchanged, go to IDLE.
    2. done: capture the unit's hi/lo into HI/LO, go to IDLE.
    3. Watchdog reaches 0: pulse timeout_err, leave HI/LO unchanged, go to IDLE.
- Done levels are never sampled in IDLE or ISSUE, so a stale done left high from a previous operation cannot commit.
- op_valid while not IDLE is ignored; requests are not queued.
- rd_req and an accepted op in the same IDLE cycle: no stall; the read sees the old HI/LO.
- Commit writes are unmodified 32-bit copies; sign handling belongs to the arithmetic units.

## Timing
- Cycle N: op accepted. N+1: ISSUE, start pulse high. N+2 onward: WAIT.
- Done sampled high at the edge ending cycle M: hi/lo updated and busy low in cycle M+1.
- MTHI/MTLO: value visible the cycle after acceptance.
- div_zero_exc and timeout_err are high for exactly one cycle, coincident with the return to IDLE.
- Reset mid-operation:
  - Immediately returns to IDLE and clears HI/LO.
  - No start pulse is emitted after reset.
  - A done arriving after reset is ignored.

## Structure
- Shared package hilo_pkg holds:
  - op_type encodings (OP_DIV, OP_MULT, OP_MTHI, OP_MTLO);
  - state enum (IDLE, ISSUE, WAIT);
  - the default TIMEOUT constant.
- Sub-module hilo_watchdog: a load/decrement counter of width $clog2(TIMEOUT+1) with an expired output. It is the only natural split.

## Test plan
- Reset, then idle: hi = lo = 0, op_ready = 1, no pulses.
- DIV, divider returns div_hi = 0xFFFFFFFF, div_lo = 0xFFFFFFFD after 33 cycles:
  - div_start pulses once, busy stays high throughout;
  - hi = 0xFFFFFFFF and lo = 0xFFFFFFFD one cycle after done.
- MULT with mult_hi = 0x00000001, mult_lo = 0x80000000:
  - hi/lo committed;
  - rd_req held during WAIT gives stall = 1 until the commit cycle, then 0.
- DIV with div_zero high in the first WAIT cycle:
  - div_zero_exc pulses once;
  - hi/lo keep their prior MTHI/MTLO values (0x12345678/0x9ABCDEF0).
- DIV with done never asserted: timeout_err pulses once after 64 WAIT cycles, busy drops, HI/LO unchanged.
- Stale div_done held high before DIV issue: no commit until a fresh done in WAIT. Also:
  - reset asserted mid-WAIT clears HI/LO to 0;
  - a later done is ignored.
